out_port_alloc: RTL

- Per-output-port switch allocator for the 5-port wormhole router.
- Chooses which input port (0..PORT_N) drives the output port and produces the one-hot select consumed by the output-port mux.
- Round-robin arbitration between packet heads, with the winner locked until its tail flit has passed.
- Tracks per-VC downstream credits so that no flit is granted without buffer space downstream.

---
 rtl/noc_pkg.sv | 19 +
 rtl/out_port_alloc_rr_arbiter.sv | 35 +++
 rtl/out_port_alloc.sv | 128 ++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared router constants and types: port count, VC/credit sizing, allocator state.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package noc_pkg;

   localparam int PORT_N       = 4;                              // highest port index
   localparam int NP           = PORT_N + 1;                     // number of input ports
   localparam int PW           = $clog2(NP);                     // port index width
   localparam int VC_N         = 2;
   localparam int VCW          = (VC_N > 1) ? $clog2(VC_N) : 1;  // at least one bit
   localparam int CREDIT_DEPTH = 4;
   localparam int CREDITW      = $clog2(CREDIT_DEPTH + 1);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } alloc_state_e;

endpackage

// File: rtl/out_port_alloc_rr_arbiter.sv
// N-way round-robin arbiter: first request strictly after ptr_i (wrapping) wins.
// Latency: purely combinational.
// Backpressure: none; vld_o low and gnt_o zero when nothing requests.
// Ports: req_i request vector, ptr_i last winner, gnt_o one-hot grant,
//        idx_o winner index, vld_o any grant.
module rr_arbiter #(
   parameter int N  = 5,
   parameter int IW = 3
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          vld_o
);

   always_comb begin
      int p;
      p     = 0;
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      // k = N revisits ptr_i itself last, so the previous winner has lowest priority.
      for (int k = 1; k <= N; k++) begin
         p = int'(ptr_i) + k;
         if (p >= N) p = p - N;
         if (!vld_o && req_i[p]) begin
            vld_o = 1'b1;
            idx_o = IW'(p);
         end
      end
      if (vld_o) gnt_o[idx_o] = 1'b1;
   end

endmodule

// File: rtl/out_port_alloc.sv
// Per-output switch allocator: round-robin over packet heads, wormhole lock until tail, per-VC credits.
// Latency: sel_o is combinational from registered state and current inputs (zero-cycle grant).
// Backpressure: no grant without a downstream credit on the target VC; a locked owner waits (bubble).
// Ports: clk/rst (sync, active-high); req_i/head_i/tail_i/vch_i per input; credit_i per VC;
//        sel_o one-hot grant to mux and input pop; busy_o high while locked to a packet.
module out_port_alloc
   import noc_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [PORT_N:0]     req_i,
   input  logic [PORT_N:0]     head_i,
   input  logic [PORT_N:0]     tail_i,
   input  logic [NP*VCW-1:0]   vch_i,
   input  logic [VC_N-1:0]     credit_i,
   output logic [PORT_N:0]     sel_o,
   output logic                busy_o
);

   alloc_state_e        state_q, state_d;
   logic [PW-1:0]       owner_q, owner_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [VCW-1:0]      lock_vc_q, lock_vc_d;
   logic                busy_q, busy_d;
   logic [CREDITW-1:0]  cnt_q [VC_N];
   logic [CREDITW-1:0]  cnt_d [VC_N];

   logic [VCW-1:0]      vch [NP];
   logic [PORT_N:0]     elig;
   logic [PORT_N:0]     arb_gnt;
   logic [PW-1:0]       arb_idx;
   logic                arb_vld;
   logic                gnt_any;
   logic [VCW-1:0]      gnt_vc;

   // A head is only eligible if its requested VC has downstream space right now.
   always_comb begin
      for (int i = 0; i < NP; i++) begin
         vch[i]  = vch_i[i*VCW +: VCW];
         elig[i] = req_i[i] & head_i[i] & (cnt_q[vch[i]] != '0);
      end
   end

   rr_arbiter #(.N(NP), .IW(PW)) u_rr (
      .req_i (elig),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .vld_o (arb_vld)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      lock_vc_d = lock_vc_q;
      sel_o     = '0;
      gnt_any   = 1'b0;
      gnt_vc    = '0;
      if (!rst) begin
         unique case (state_q)
            IDLE: begin
               if (arb_vld) begin
                  sel_o   = arb_gnt;
                  gnt_any = 1'b1;
                  gnt_vc  = vch[arb_idx];
                  if (tail_i[arb_idx]) begin
                     ptr_d = arb_idx;
                  end else begin
                     state_d   = LOCKED;
                     owner_d   = arb_idx;
                     lock_vc_d = vch[arb_idx];
                  end
               end
            end
            LOCKED: begin
               // Body flits follow the VC latched at the head; other inputs are ignored.
               if (req_i[owner_q] && (cnt_q[lock_vc_q] != '0)) begin
                  sel_o[owner_q] = 1'b1;
                  gnt_any        = 1'b1;
                  gnt_vc         = lock_vc_q;
                  if (tail_i[owner_q]) begin
                     state_d = IDLE;
                     ptr_d   = owner_q;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d == LOCKED);
      for (int v = 0; v < VC_N; v++) begin
         cnt_d[v] = cnt_q[v]
                  - CREDITW'(gnt_any && (gnt_vc == VCW'(v)))
                  + CREDITW'(credit_i[v]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         ptr_q     <= PW'(PORT_N);   // port 0 gets first priority
         lock_vc_q <= '0;
         busy_q    <= 1'b0;
         for (int v = 0; v < VC_N; v++) cnt_q[v] <= CREDITW'(CREDIT_DEPTH);
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         lock_vc_q <= lock_vc_d;
         busy_q    <= busy_d;
         for (int v = 0; v < VC_N; v++) cnt_q[v] <= cnt_d[v];
      end
   end

   assign busy_o = busy_q;

   a_sel_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(sel_o));
   a_sel_req:    assert property (@(posedge clk) disable iff (rst) ((sel_o & ~req_i) == '0));
   a_idle_head:  assert property (@(posedge clk) disable iff (rst)
                                  (state_q == IDLE) |-> ((req_i & ~head_i) == '0));
   for (genvar v = 0; v < VC_N; v++) begin : g_cnt_chk
      a_cnt_max: assert property (@(posedge clk) disable iff (rst)
                                  cnt_q[v] <= CREDITW'(CREDIT_DEPTH));
   end

endmodule
